// File: rtl/aes_key_sched_seq_if.sv
// Key-schedule engine bus: key load handshake, status, and round-key readout.
//   key/key_valid/key_ready : cipher key load (word j = key[32*j+:32])
//   busy/sched_valid        : expansion in progress / all round keys stored
//   rk_idx -> rk_out/rk_valid/rk_err : registered round-key read port
interface aes_key_sched_seq_if #(parameter int Nk = 4);
  logic [32*Nk-1:0] key;
  logic             key_valid;
  logic             key_ready;
  logic             busy;
  logic             sched_valid;
  logic [3:0]       rk_idx;
  logic [127:0]     rk_out;
  logic             rk_valid;
  logic             rk_err;

  modport master (output key, key_valid, rk_idx,
                  input  key_ready, busy, sched_valid, rk_out, rk_valid, rk_err);
  modport slave  (input  key, key_valid, rk_idx,
                  output key_ready, busy, sched_valid, rk_out, rk_valid, rk_err);
endinterface

// File: rtl/aes_key_sched_seq.sv
// Iterative AES key expansion: one 32-bit word per cycle through a single
// shared SubWord, all Nr+1 round keys kept in a word store and served by index.
// Ports: clk, rst (sync, active high), bus (slave modport of aes_key_sched_seq_if).
// Word values follow FIPS-197 notation: the first byte of a word is its MSB byte.
module aes_key_sched_seq #(
  parameter int Nk = 4,
  parameter int Nr = Nk + 6
) (
  input logic               clk,
  input logic               rst,
  aes_key_sched_seq_if.slave bus
);
  localparam int NW = 4 * (Nr + 1);

  typedef enum logic [1:0] {IDLE, EXPAND, READY} state_e;

  state_e       state_q, state_d;
  logic [5:0]   i_q, i_d;       // index of the word being produced
  logic [2:0]   m_q, m_d;       // i % Nk, tracked incrementally
  logic [7:0]   rcon_q, rcon_d;
  logic [31:0]  w_q [NW];       // word store, not cleared by reset

  logic         key_ready, accept;
  logic [31:0]  prev_w, old_w, sub_in, sub_out, new_w;
  logic         rk_hit;
  logic [5:0]   rk_base;
  logic [127:0] rk_out_d, rk_out_q;
  logic         rk_valid_q, rk_err_q;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p  = 8'h00;
    aa = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // S-box computed as GF(2^8) inverse (b^254, 0 maps to 0) plus the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] sq, inv;
    sq  = b;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  assign key_ready       = (state_q == IDLE) || (state_q == READY);
  assign accept          = bus.key_valid && key_ready;
  assign bus.key_ready   = key_ready;
  assign bus.busy        = (state_q == EXPAND);
  assign bus.sched_valid = (state_q == READY);

  // Word datapath: RotWord only on the rcon step; rcon lands in the first byte.
  always_comb begin
    prev_w  = w_q[i_q - 6'd1];
    old_w   = w_q[i_q - 6'(Nk)];
    sub_in  = (m_q == 3'd0) ? {prev_w[23:0], prev_w[31:24]} : prev_w;
    sub_out = {sbox(sub_in[31:24]), sbox(sub_in[23:16]),
               sbox(sub_in[15:8]),  sbox(sub_in[7:0])};
    if (m_q == 3'd0)
      new_w = old_w ^ sub_out ^ {rcon_q, 24'h0};
    else if (Nk > 6 && m_q == 3'd4)
      new_w = old_w ^ sub_out;
    else
      new_w = old_w ^ prev_w;
  end

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    m_d     = m_q;
    rcon_d  = rcon_q;
    case (state_q)
      IDLE, READY: begin
        if (accept) begin
          state_d = EXPAND;
          i_d     = 6'(Nk);
          m_d     = 3'd0;
          rcon_d  = 8'h01;
        end
      end
      EXPAND: begin
        i_d = i_q + 6'd1;
        m_d = (m_q == 3'(Nk - 1)) ? 3'd0 : m_q + 3'd1;
        if (m_q == 3'd0) rcon_d = xtime(rcon_q);
        if (i_q == 6'(NW - 1)) state_d = READY;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      i_q     <= 6'd0;
      m_q     <= 3'd0;
      rcon_q  <= 8'h01;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      m_q     <= m_d;
      rcon_q  <= rcon_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (accept) begin
        for (int j = 0; j < Nk; j++) w_q[j] <= bus.key[32*j +: 32];
      end else if (state_q == EXPAND) begin
        w_q[i_q] <= new_w;
      end
    end
  end

  // Readout: the store is read before the accept edge rewrites it, so a read
  // in the accept cycle still returns the old schedule.
  always_comb begin
    rk_base  = {bus.rk_idx, 2'b00};
    rk_hit   = bus.sched_valid && (bus.rk_idx <= 4'(Nr));
    rk_out_d = 128'h0;
    if (rk_hit)
      rk_out_d = {w_q[rk_base + 6'd3], w_q[rk_base + 6'd2],
                  w_q[rk_base + 6'd1], w_q[rk_base]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rk_out_q   <= 128'h0;
      rk_valid_q <= 1'b0;
      rk_err_q   <= 1'b0;
    end else begin
      rk_out_q   <= rk_out_d;
      rk_valid_q <= rk_hit;
      rk_err_q   <= (bus.rk_idx > 4'(Nr));
    end
  end

  assign bus.rk_out   = rk_out_q;
  assign bus.rk_valid = rk_valid_q;
  assign bus.rk_err   = rk_err_q;
endmodule
